tlb_sa_walk: RTL and testbench
==============================

Name: tlb_sa_walk

Overview:
Parametrised set-associative TLB with PCID-tagged entries, miss-driven page-walk fill and PCID-selective flush. Successor to the direct lookup cache used in the TLB benches. Adds configurable sets/ways, valid/ready request handshake, walker interface, round-robin replacement and invalidation. Sits between the core address generation stage and the page-table walker.

Parameters:
VA_W, 64, virtual address width
PA_W, 64, physical address width
PCID_W, 12, process-context ID width
OFF_W, 12, page offset width (4 KiB pages)
SETS, 8, number of sets (power of 2, >=2)
WAYS, 4, ways per set (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  lookup request
req_ready  out  1  high only in IDLE with no flush accepted this cycle
req_va  in  VA_W  virtual address
req_pcid  in  PCID_W  context of request
resp_valid  out  1  one-cycle pulse, translation result
resp_addr  out  PA_W  {ppn, va offset}
resp_hit  out  1  with resp_valid: 1 = TLB hit, 0 = filled from walk
miss  out  1  one-cycle pulse when a lookup misses
walk_req_valid  out  1  held high in WALK
walk_req_vpn  out  VA_W-OFF_W  VPN to walk
walk_req_pcid  out  PCID_W  context to walk
walk_resp_valid  in  1  walker result valid (sampled only in WALK)
walk_resp_ppn  in  PA_W-OFF_W  physical page number
flush_valid  in  1  invalidate request
flush_all  in  1  1 = drop all entries, 0 = only matching flush_pcid
flush_pcid  in  PCID_W  context to invalidate
flush_ready  out  1  high only in IDLE

Behaviour:
- vpn = va[VA_W-1:OFF_W]; set = vpn[log2(SETS)-1:0]; tag = vpn upper bits; entry = {valid, tag, pcid, ppn}.
- Hit requires valid & tag match & pcid match. Multiple matches cannot occur by construction; if they do, lowest way wins.
- Reset (async): all valid bits 0, RR pointers 0, state IDLE, all outputs 0 except req_ready/flush_ready, which go to 1 one cycle after rst deasserts.
- FSM states IDLE, LOOKUP, WALK, FILL.
- IDLE:
  - flush_valid takes priority over req_valid in the same cycle. Flush completes in that edge; req_ready is 0 that cycle.
  - req_valid & req_ready: register va/pcid, go to LOOKUP.
- LOOKUP (1 cycle):
  - Hit: resp_valid=1, resp_hit=1, resp_addr={ppn, va[OFF_W-1:0]}, return to IDLE. Lookup latency is 2 cycles from accept.
  - Miss: miss=1 for one cycle, go to WALK.
- WALK: walk_req_valid=1 with registered vpn/pcid until walk_resp_valid is seen; capture ppn, go to FILL. No timeout.
- FILL (1 cycle):
  - Write the entry into the victim way: lowest invalid way in the set; if none, the set's RR pointer, then pointer +1 mod WAYS (wraps).
  - resp_valid=1, resp_hit=0, resp_addr from walk result. Return to IDLE.
- Hits do not update RR pointers.
- PA width rule: resp_addr = {ppn, offset}, exactly PA_W bits. ppn is zero-extended/truncated by parameter widths, never by the walker.
- Flush clears valid only; RR pointers are unchanged. flush_all ignores flush_pcid.
- Reset during WALK/FILL: request abandoned, no resp_valid, walk_req_valid drops immediately (async).
- Outputs resp_*/miss are registered pulses, 0 in all other cycles.

Decomposition:
- Shared package tlb_pkg: state encoding, OFF_W/PCID_W defaults, IDX_W/TAG_W/WAY_W derivation functions, entry field layout.
- Sub-module tlb_way_match: combinational compare across WAYS for one set. Outputs hit, hit_way, ppn, first_invalid_way, any_invalid.
- Top holds entry arrays, RR pointers and the FSM.

Test Plan:
- Cold miss, pcid=0, va=0xfffffffffffffff1:
  - miss pulse; walk_req_vpn=0xfffffffffffff, walk_req_pcid=0.
  - Walker answers ppn=0x123 after 3 cycles -> resp_valid, resp_hit=0, resp_addr=0x123ff1.
  - Same request again -> resp_hit=1, resp_addr=0x123ff1, 2 cycles after accept, no walk.
- PCID isolation:
  - After the above, va=0xfffffffffffffff1 pcid=1 -> miss, walk; fill ppn=0x456 -> 0x456ff1.
  - pcid=0 still hits 0x123ff1; pcid=1 hits 0x456ff1.
- Replacement, SETS=8 WAYS=4:
  - Fill vpns 0x0,0x8,0x10,0x18 (set 0) -> ways 0..3.
  - Fifth vpn 0x20 evicts way 0.
  - Lookup vpn 0x0 -> miss; vpn 0x8 -> hit.
  - Subsequent evictions cycle ways 1,2,3,0 (wrap).
- Flush:
  - Entries for pcid 0 and 1 resident; flush_valid, flush_all=0, flush_pcid=1 -> pcid1 lookups miss, pcid0 still hit.
  - flush_all=1 -> everything misses.
  - flush_valid and req_valid in the same cycle -> flush applied, req_ready=0, request accepted next cycle.
- Handshake stalls:
  - During WALK, req_ready=0 and flush_ready=0; held req_valid is not accepted until after FILL.
  - walk_resp_valid pulsed while in IDLE -> ignored, no state change.
- Reset mid-walk:
  - rst asserted in WALK -> walk_req_valid falls without a clock edge.
  - After release, all prior entries miss, no stray resp_valid.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared definitions for the set-associative, PCID-tagged TLB.
//   - state_t   : controller states
//   - DEF_*     : default page-offset and PCID widths
//   - idx_w / tag_w / way_w : derived field widths
// Entry field layout (stored as parallel arrays in the top level):
//   {valid, tag[TAG_W], pcid[PCID_W], ppn[PA_W-OFF_W]}
//   vpn = va[VA_W-1:OFF_W], set index = vpn[IDX_W-1:0], tag = vpn[VPN_W-1:IDX_W]
package tlb_pkg;

    localparam int DEF_OFF_W  = 12;
    localparam int DEF_PCID_W = 12;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WALK   = 2'd2,
        S_FILL   = 2'd3
    } state_t;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int way_w(input int ways);
        return $clog2(ways);
    endfunction

    function automatic int tag_w(input int va_w, input int off_w, input int sets);
        return va_w - off_w - $clog2(sets);
    endfunction

endpackage

// File: rtl/tlb_sa_walk_if.sv
// Bundle of the TLB request/response, walker and flush channels.
//   master : core + page-table walker side (drives requests, walk results, flushes)
//   slave  : TLB side (drives ready, responses, miss pulse, walk requests)
interface tlb_sa_walk_if #(
    parameter int VA_W   = 64,
    parameter int PA_W   = 64,
    parameter int PCID_W = 12,
    parameter int OFF_W  = 12
);
    // lookup request / response
    logic                  req_valid;
    logic                  req_ready;
    logic [VA_W-1:0]       req_va;
    logic [PCID_W-1:0]     req_pcid;
    logic                  resp_valid;
    logic [PA_W-1:0]       resp_addr;
    logic                  resp_hit;
    logic                  miss;
    // page-table walker
    logic                  walk_req_valid;
    logic [VA_W-OFF_W-1:0] walk_req_vpn;
    logic [PCID_W-1:0]     walk_req_pcid;
    logic                  walk_resp_valid;
    logic [PA_W-OFF_W-1:0] walk_resp_ppn;
    // invalidation
    logic                  flush_valid;
    logic                  flush_all;
    logic [PCID_W-1:0]     flush_pcid;
    logic                  flush_ready;

    modport master (
        output req_valid, req_va, req_pcid,
        output walk_resp_valid, walk_resp_ppn,
        output flush_valid, flush_all, flush_pcid,
        input  req_ready, resp_valid, resp_addr, resp_hit, miss,
        input  walk_req_valid, walk_req_vpn, walk_req_pcid, flush_ready
    );

    modport slave (
        input  req_valid, req_va, req_pcid,
        input  walk_resp_valid, walk_resp_ppn,
        input  flush_valid, flush_all, flush_pcid,
        output req_ready, resp_valid, resp_addr, resp_hit, miss,
        output walk_req_valid, walk_req_vpn, walk_req_pcid, flush_ready
    );
endinterface

// File: rtl/tlb_way_match.sv
// Combinational tag/PCID compare across all ways of one set.
// Inputs : per-way valid/tag/pcid/ppn of the selected set, lookup tag and pcid.
// Outputs: hit, hit_way, hit_ppn (lowest matching way wins),
//          first_invalid_way (lowest invalid way), any_invalid.
module tlb_way_match
    import tlb_pkg::*;
#(
    parameter  int WAYS   = 4,
    parameter  int TAG_W  = 49,
    parameter  int PCID_W = 12,
    parameter  int PPN_W  = 52,
    localparam int WAY_W  = way_w(WAYS)
) (
    input  logic [WAYS-1:0]             valid,
    input  logic [WAYS-1:0][TAG_W-1:0]  tag,
    input  logic [WAYS-1:0][PCID_W-1:0] pcid,
    input  logic [WAYS-1:0][PPN_W-1:0]  ppn,
    input  logic [TAG_W-1:0]            lookup_tag,
    input  logic [PCID_W-1:0]           lookup_pcid,
    output logic                        hit,
    output logic [WAY_W-1:0]            hit_way,
    output logic [PPN_W-1:0]            hit_ppn,
    output logic [WAY_W-1:0]            first_invalid_way,
    output logic                        any_invalid
);

    // Scanning from the top way down lets the lowest qualifying way overwrite
    // the result last, giving lowest-way priority for both searches.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a variable unassigned and no latch is inferred.
        hit               = 1'b0;
        hit_way           = '0;
        hit_ppn           = '0;
        first_invalid_way = '0;
        any_invalid       = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[w] && tag[w] == lookup_tag && pcid[w] == lookup_pcid) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
                hit_ppn = ppn[w];
            end
            if (!valid[w]) begin
                any_invalid       = 1'b1;
                first_invalid_way = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/tlb_sa_walk.sv
// Set-associative PCID-tagged TLB with miss-driven page-walk fill,
// round-robin replacement and PCID-selective / global flush.
// Ports:
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : tlb_sa_walk_if.slave -- lookup request/response, miss pulse,
//              walker request/response, flush request/ready
module tlb_sa_walk
    import tlb_pkg::*;
#(
    parameter int VA_W   = 64,
    parameter int PA_W   = 64,
    parameter int PCID_W = DEF_PCID_W,
    parameter int OFF_W  = DEF_OFF_W,
    parameter int SETS   = 8,
    parameter int WAYS   = 4
) (
    input logic          clk,
    input logic          rst,
    tlb_sa_walk_if.slave bus
);

    localparam int VPN_W = VA_W - OFF_W;
    localparam int PPN_W = PA_W - OFF_W;
    localparam int IDX_W = idx_w(SETS);
    localparam int TAG_W = tag_w(VA_W, OFF_W, SETS);
    localparam int WAY_W = way_w(WAYS);

    state_t state_q, state_d;
    logic   ready_en_q;  // holds ready low for the first cycle after reset

    logic [VA_W-1:0]   va_q;
    logic [PCID_W-1:0] pcid_q;
    logic [PPN_W-1:0]  ppn_q;
    logic              resp_valid_q, resp_hit_q, miss_q;
    logic [PA_W-1:0]   resp_addr_q;

    logic [SETS-1:0][WAYS-1:0]  valid_q;
    logic [SETS-1:0][WAY_W-1:0] rr_q;
    logic [WAYS-1:0][TAG_W-1:0]  tag_mem  [SETS];
    logic [WAYS-1:0][PCID_W-1:0] pcid_mem [SETS];
    logic [WAYS-1:0][PPN_W-1:0]  ppn_mem  [SETS];

    logic [VPN_W-1:0] vpn;
    logic [IDX_W-1:0] set_idx;
    logic [TAG_W-1:0] tag;

    logic             hit, any_invalid;
    logic [WAY_W-1:0] hit_way, first_invalid_way, victim;
    logic [PPN_W-1:0] hit_ppn;
    logic             use_rr;

    logic             flush_ready, req_ready;
    logic             accept, do_flush, capture, fill_en;
    logic             resp_valid_d, resp_hit_d, miss_d;
    logic [PA_W-1:0]  resp_addr_d;

    assign vpn     = va_q[VA_W-1:OFF_W];
    assign set_idx = vpn[IDX_W-1:0];
    assign tag     = vpn[VPN_W-1:IDX_W];

    tlb_way_match #(
        .WAYS   (WAYS),
        .TAG_W  (TAG_W),
        .PCID_W (PCID_W),
        .PPN_W  (PPN_W)
    ) u_match (
        .valid             (valid_q[set_idx]),
        .tag               (tag_mem[set_idx]),
        .pcid              (pcid_mem[set_idx]),
        .ppn               (ppn_mem[set_idx]),
        .lookup_tag        (tag),
        .lookup_pcid       (pcid_q),
        .hit               (hit),
        .hit_way           (hit_way),
        .hit_ppn           (hit_ppn),
        .first_invalid_way (first_invalid_way),
        .any_invalid       (any_invalid)
    );

    // A fill that already matches reuses its own way so a translation is never
    // held twice; otherwise lowest invalid way, then the set's RR pointer.
    always_comb begin
        victim = rr_q[set_idx];
        use_rr = 1'b0;
        if (hit) begin
            victim = hit_way;
        end else if (any_invalid) begin
            victim = first_invalid_way;
        end else begin
            use_rr = 1'b1;
        end
    end

    assign flush_ready = (state_q == S_IDLE) && ready_en_q;
    assign req_ready   = flush_ready && !bus.flush_valid;  // flush wins the cycle

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        do_flush     = 1'b0;
        capture      = 1'b0;
        fill_en      = 1'b0;
        resp_valid_d = 1'b0;
        resp_hit_d   = 1'b0;
        miss_d       = 1'b0;
        resp_addr_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.flush_valid && flush_ready) begin
                    do_flush = 1'b1;
                end else if (bus.req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid_d = 1'b1;
                    resp_hit_d   = 1'b1;
                    resp_addr_d  = {hit_ppn, va_q[OFF_W-1:0]};
                    state_d      = S_IDLE;
                end else begin
                    miss_d  = 1'b1;
                    state_d = S_WALK;
                end
            end
            S_WALK: begin
                if (bus.walk_resp_valid) begin
                    capture = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                fill_en      = 1'b1;
                resp_valid_d = 1'b1;
                resp_addr_d  = {ppn_q, va_q[OFF_W-1:0]};
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ready_en_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q    <= state_d;
            ready_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            va_q         <= '0;
            pcid_q       <= '0;
            ppn_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_addr_q  <= '0;
            miss_q       <= 1'b0;
            valid_q      <= '0;
            rr_q         <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_hit_q   <= resp_hit_d;
            resp_addr_q  <= resp_addr_d;
            miss_q       <= miss_d;
            if (accept) begin
                va_q   <= bus.req_va;
                pcid_q <= bus.req_pcid;
            end
            if (capture) begin
                ppn_q <= bus.walk_resp_ppn;
            end
            if (do_flush) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        if (bus.flush_all || pcid_mem[s][w] == bus.flush_pcid) begin
                            valid_q[s][w] <= 1'b0;
                        end
                    end
                end
            end
            if (fill_en) begin
                valid_q[set_idx][victim] <= 1'b1;
                if (use_rr) begin
                    rr_q[set_idx] <= rr_q[set_idx] + 1'b1;  // wraps: WAYS is a power of 2
                end
            end
        end
    end

    // NOTE: entry payload arrays carry no reset; the valid bits alone decide
    // whether a way holds anything, which keeps these as plain RAM-style arrays.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[set_idx][victim]  <= tag;
            pcid_mem[set_idx][victim] <= pcid_q;
            ppn_mem[set_idx][victim]  <= ppn_q;
        end
    end

    assign bus.req_ready      = req_ready;
    assign bus.flush_ready    = flush_ready;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_hit       = resp_hit_q;
    assign bus.resp_addr      = resp_addr_q;
    assign bus.miss           = miss_q;
    assign bus.walk_req_valid = (state_q == S_WALK);
    assign bus.walk_req_vpn   = vpn;
    assign bus.walk_req_pcid  = pcid_q;

endmodule

// File: tb/tb_tlb_sa_walk.sv
// Self-checking bench for tlb_sa_walk: directed scenarios followed by random
// lookups/flushes, all checked against a behavioural TLB model.
module tb_tlb_sa_walk;

    localparam int VA_W   = 64;
    localparam int PA_W   = 64;
    localparam int PCID_W = 12;
    localparam int OFF_W  = 12;
    localparam int SETS   = 8;
    localparam int WAYS   = 4;
    localparam int VPN_W  = VA_W - OFF_W;
    localparam int PPN_W  = PA_W - OFF_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tlb_sa_walk_if #(.VA_W(VA_W), .PA_W(PA_W), .PCID_W(PCID_W), .OFF_W(OFF_W)) bus ();

    tlb_sa_walk #(
        .VA_W(VA_W), .PA_W(PA_W), .PCID_W(PCID_W), .OFF_W(OFF_W), .SETS(SETS), .WAYS(WAYS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: whole VPN stored per entry, set = vpn mod SETS.
    bit                m_valid [SETS][WAYS];
    logic [VPN_W-1:0]  m_vpn   [SETS][WAYS];
    logic [PCID_W-1:0] m_pcid  [SETS][WAYS];
    logic [PPN_W-1:0]  m_ppn   [SETS][WAYS];
    int                m_rr    [SETS];

    localparam logic [VA_W-1:0] VA1 = 64'hffff_ffff_ffff_fff1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic int m_set(input logic [VPN_W-1:0] vpn);
        return int'(vpn % VPN_W'(SETS));
    endfunction

    function automatic int m_find(input logic [VPN_W-1:0] vpn, input logic [PCID_W-1:0] pcid);
        int s = m_set(vpn);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_vpn[s][w] == vpn && m_pcid[s][w] == pcid) return w;
        return -1;
    endfunction

    function automatic void m_fill(input logic [VPN_W-1:0] vpn, input logic [PCID_W-1:0] pcid,
                                   input logic [PPN_W-1:0] ppn);
        int s = m_set(vpn);
        int v = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (!m_valid[s][w]) begin
                v = w;
                break;
            end
        end
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_valid[s][v] = 1'b1;
        m_vpn[s][v]   = vpn;
        m_pcid[s][v]  = pcid;
        m_ppn[s][v]   = ppn;
    endfunction

    function automatic void m_flush(input bit all, input logic [PCID_W-1:0] pcid);
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (all || m_pcid[s][w] == pcid) m_valid[s][w] = 1'b0;
    endfunction

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
    endfunction

    // Starts and ends at a negedge. On a model miss the walker answers after
    // `delay` WALK cycles with walk_ppn; optionally a second request is held
    // on the request channel while the walk is outstanding.
    task automatic lookup(input logic [VA_W-1:0] va, input logic [PCID_W-1:0] pcid,
                          input int delay, input logic [PPN_W-1:0] walk_ppn,
                          input bit hold_en = 1'b0, input logic [VA_W-1:0] hold_va = '0,
                          input logic [PCID_W-1:0] hold_pcid = '0);
        logic [VPN_W-1:0] vpn = va[VA_W-1:OFF_W];
        int s = m_set(vpn);
        int w = m_find(vpn, pcid);
        #1;
        check("accept_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_va    = va;
        bus.req_pcid  = pcid;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("lookup_no_resp", bus.resp_valid, 0);
        @(negedge clk);
        if (w >= 0) begin
            check("hit_valid", bus.resp_valid, 1);
            check("hit_flag", bus.resp_hit, 1);
            check("hit_addr", bus.resp_addr, {m_ppn[s][w], va[OFF_W-1:0]});
            check("hit_no_miss", bus.miss, 0);
            check("hit_no_walk", bus.walk_req_valid, 0);
        end else begin
            check("miss_pulse", bus.miss, 1);
            check("miss_no_resp", bus.resp_valid, 0);
            check("walk_valid", bus.walk_req_valid, 1);
            check("walk_vpn", bus.walk_req_vpn, vpn);
            check("walk_pcid", bus.walk_req_pcid, pcid);
            if (hold_en) begin
                bus.req_valid = 1'b1;
                bus.req_va    = hold_va;
                bus.req_pcid  = hold_pcid;
            end
            for (int i = 0; i < delay; i++) begin
                #1;
                check("walk_held", bus.walk_req_valid, 1);
                check("walk_req_ready", bus.req_ready, 0);
                check("walk_flush_ready", bus.flush_ready, 0);
                @(negedge clk);
            end
            bus.walk_resp_valid = 1'b1;
            bus.walk_resp_ppn   = walk_ppn;
            @(negedge clk);
            bus.walk_resp_valid = 1'b0;
            bus.walk_resp_ppn   = '0;
            check("fill_walk_low", bus.walk_req_valid, 0);
            check("fill_no_resp", bus.resp_valid, 0);
            check("fill_req_ready", bus.req_ready, 0);
            @(negedge clk);
            check("fill_valid", bus.resp_valid, 1);
            check("fill_flag", bus.resp_hit, 0);
            check("fill_addr", bus.resp_addr, {walk_ppn, va[OFF_W-1:0]});
            m_fill(vpn, pcid, walk_ppn);
        end
        check("done_ready", bus.req_ready, 1);
    endtask

    task automatic flush(input bit all, input logic [PCID_W-1:0] pcid);
        #1;
        bus.flush_valid = 1'b1;
        bus.flush_all   = all;
        bus.flush_pcid  = pcid;
        #1;
        check("flush_ready", bus.flush_ready, 1);
        check("flush_blocks_req", bus.req_ready, 0);
        @(negedge clk);
        bus.flush_valid = 1'b0;
        m_flush(all, pcid);
    endtask

    function automatic logic [PPN_W-1:0] rand_ppn();
        return PPN_W'({$urandom(), $urandom()});
    endfunction

    initial begin
        rst                 = 1'b1;
        bus.req_valid       = 1'b0;
        bus.req_va          = '0;
        bus.req_pcid        = '0;
        bus.walk_resp_valid = 1'b0;
        bus.walk_resp_ppn   = '0;
        bus.flush_valid     = 1'b0;
        bus.flush_all       = 1'b0;
        bus.flush_pcid      = '0;
        m_reset();

        // Reset state
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_flush_ready", bus.flush_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_miss", bus.miss, 0);
        check("rst_walk_valid", bus.walk_req_valid, 0);
        check("rst_resp_addr", bus.resp_addr, 0);
        rst = 1'b0;
        #1;
        check("rel_req_ready_low", bus.req_ready, 0);
        @(negedge clk);
        check("rel_req_ready", bus.req_ready, 1);
        check("rel_flush_ready", bus.flush_ready, 1);

        // Cold miss, refill hit, PCID isolation
        lookup(VA1, 12'd0, 3, 52'h123);
        check("cold_addr", bus.resp_addr, 64'h123ff1);
        lookup(VA1, 12'd0, 0, 52'h0);
        check("rehit_flag", bus.resp_hit, 1);
        check("rehit_addr", bus.resp_addr, 64'h123ff1);
        lookup(VA1, 12'd1, 2, 52'h456);
        check("pcid1_addr", bus.resp_addr, 64'h456ff1);
        lookup(VA1, 12'd0, 0, 52'h0);
        check("iso_pcid0", bus.resp_addr, 64'h123ff1);
        lookup(VA1, 12'd1, 0, 52'h0);
        check("iso_pcid1", bus.resp_addr, 64'h456ff1);

        // Replacement in set 0
        for (int i = 0; i < 5; i++) begin
            lookup(VA_W'(i * 8) << OFF_W, 12'd0, 1, 52'h1000 + PPN_W'(i));
            check("set0_cold", bus.resp_hit, 0);
        end
        lookup(64'h8 << OFF_W, 12'd0, 0, 52'h0);
        check("evict_keep_8", bus.resp_hit, 1);
        lookup(64'h0 << OFF_W, 12'd0, 1, 52'h2000);
        check("evict_lost_0", bus.resp_hit, 0);
        lookup(64'h28 << OFF_W, 12'd0, 1, 52'h2028);
        lookup(64'h30 << OFF_W, 12'd0, 1, 52'h2030);
        lookup(64'h38 << OFF_W, 12'd0, 1, 52'h2038);
        lookup(64'h0 << OFF_W, 12'd0, 0, 52'h0);
        check("wrap_keep_0", bus.resp_hit, 1);
        lookup(64'h28 << OFF_W, 12'd0, 0, 52'h0);
        check("wrap_keep_28", bus.resp_hit, 1);
        lookup(64'h30 << OFF_W, 12'd0, 0, 52'h0);
        check("wrap_keep_30", bus.resp_hit, 1);
        lookup(64'h20 << OFF_W, 12'd0, 2, 52'h3020);
        check("wrap_lost_20", bus.resp_hit, 0);

        // PCID-selective flush, then global flush
        flush(1'b0, 12'd1);
        lookup(VA1, 12'd1, 1, 52'h789);
        check("flush1_miss", bus.resp_hit, 0);
        lookup(VA1, 12'd0, 0, 52'h0);
        check("flush1_keep0", bus.resp_hit, 1);
        flush(1'b1, 12'h5);
        lookup(VA1, 12'd0, 1, 52'h123);
        check("flushall_va1", bus.resp_hit, 0);
        lookup(64'h0 << OFF_W, 12'd0, 1, 52'h2000);
        check("flushall_vpn0", bus.resp_hit, 0);

        // Flush and request in the same cycle
        #1;
        bus.flush_valid = 1'b1;
        bus.flush_all   = 1'b0;
        bus.flush_pcid  = 12'd0;
        bus.req_valid   = 1'b1;
        bus.req_va      = 64'h28 << OFF_W;
        bus.req_pcid    = 12'd0;
        #1;
        check("both_req_ready", bus.req_ready, 0);
        check("both_flush_ready", bus.flush_ready, 1);
        @(negedge clk);
        bus.flush_valid = 1'b0;
        m_flush(1'b0, 12'd0);
        lookup(64'h28 << OFF_W, 12'd0, 1, 52'hAAA);
        check("both_then_miss", bus.resp_hit, 0);

        // Walker response while idle is ignored
        @(negedge clk);
        bus.walk_resp_valid = 1'b1;
        bus.walk_resp_ppn   = 52'hDEAD;
        @(negedge clk);
        bus.walk_resp_valid = 1'b0;
        check("idle_walk_valid", bus.walk_req_valid, 0);
        check("idle_walk_resp", bus.resp_valid, 0);
        check("idle_walk_miss", bus.miss, 0);
        check("idle_walk_ready", bus.req_ready, 1);
        lookup(64'h28 << OFF_W, 12'd0, 0, 52'h0);
        check("idle_walk_hit", bus.resp_addr, 64'hAAA000);

        // Request held during a walk is accepted only after the fill response
        lookup(64'h40 << OFF_W, 12'd2, 3, 52'hBBB, 1'b1, 64'h48 << OFF_W, 12'd2);
        lookup(64'h48 << OFF_W, 12'd2, 1, 52'hCCC);
        check("held_miss", bus.resp_hit, 0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                flush(1'($urandom_range(0, 3) == 0), PCID_W'($urandom_range(0, 2)));
            end else begin
                logic [VPN_W-1:0] v = VPN_W'($urandom_range(0, 23));
                if ($urandom_range(0, 1) == 1) v = v | 52'hABCDE00000000;
                lookup({v, 12'($urandom())}, PCID_W'($urandom_range(0, 2)),
                       $urandom_range(0, 3), rand_ppn());
            end
        end

        // Reset in the middle of a walk
        #1;
        bus.req_valid = 1'b1;
        bus.req_va    = 64'h5555_5555_5555_5123;
        bus.req_pcid  = 12'habc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_walk_valid", bus.walk_req_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_walk_drop", bus.walk_req_valid, 0);
        check("rst_miss_drop", bus.miss, 0);
        check("rst_ready_drop", bus.req_ready, 0);
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_resp", bus.resp_valid, 0);
            check("post_rst_walk", bus.walk_req_valid, 0);
        end
        lookup(VA1, 12'd0, 1, 52'h321);
        check("post_rst_miss", bus.resp_hit, 0);
        lookup(VA1, 12'd0, 0, 52'h0);
        check("post_rst_hit", bus.resp_addr, 64'h321ff1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
